// File: rtl/gbe_tx_serializer_if.sv
// gbe_tx_if: read strobes and FIFO words in, tx word stream and status out.
interface gbe_tx_if #(
  parameter int WORDS_PER_PACKET = 7,
  parameter int WORD_BITS = 64,
  parameter int PKT_CTR_BITS = 32
);
  logic ce, gbe_re, lb_re;
  logic [WORDS_PER_PACKET*WORD_BITS-1:0] gbe_dout, lb_dout;
  logic [31:0] gbe_dest_ip, lb_dest_ip, tx_dest_ip;
  logic [WORD_BITS-1:0] tx_data;
  logic tx_valid, tx_eof, tx_is_lb, overrun;
  logic [PKT_CTR_BITS-1:0] gbe_pkt_cnt, lb_pkt_cnt;
  modport master (
    output ce, gbe_re, lb_re, gbe_dout, lb_dout, gbe_dest_ip, lb_dest_ip,
    input tx_data, tx_valid, tx_eof, tx_dest_ip, tx_is_lb, gbe_pkt_cnt, lb_pkt_cnt, overrun
  );
  modport slave (
    input ce, gbe_re, lb_re, gbe_dout, lb_dout, gbe_dest_ip, lb_dest_ip,
    output tx_data, tx_valid, tx_eof, tx_dest_ip, tx_is_lb, gbe_pkt_cnt, lb_pkt_cnt, overrun
  );
endinterface

// File: rtl/gbe_tx_serializer.sv
// gbe_tx_serializer: splits one-packet FIFO entries into tx words with per-source counters.
module gbe_tx_serializer #(
  parameter int WORDS_PER_PACKET = 7,
  parameter int WORDS_PER_PACKET_BITS = 3,
  parameter int WORD_BITS = 64,
  parameter int RD_LATENCY = 1,
  parameter int PKT_CTR_BITS = 32
) (
  input logic clk,
  input logic rst,
  gbe_tx_if.slave bus
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q;
  logic [RD_LATENCY-1:0] gbe_dly_q, lb_dly_q;
  logic [WORDS_PER_PACKET_BITS-1:0] idx_q;
  logic [WORDS_PER_PACKET-1:0][WORD_BITS-1:0] pkt_q;
  logic [WORD_BITS-1:0] tx_data_q;
  logic [31:0] tx_dest_ip_q;
  logic tx_valid_q, tx_eof_q, tx_is_lb_q, overrun_q;
  logic [PKT_CTR_BITS-1:0] gbe_cnt_q, lb_cnt_q;
  logic gbe_ld, lb_ld, last, accept;
  assign gbe_ld = gbe_dly_q[RD_LATENCY-1];
  assign lb_ld = lb_dly_q[RD_LATENCY-1];
  assign last = idx_q == WORDS_PER_PACKET_BITS'(WORDS_PER_PACKET - 1);
  // a new packet may land on the eof word so back-to-back packets leave no gap
  assign accept = (gbe_ld || lb_ld) && (state_q == IDLE || last);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gbe_dly_q <= '0;
      lb_dly_q <= '0;
      idx_q <= '0;
      pkt_q <= '0;
      tx_data_q <= '0;
      tx_dest_ip_q <= '0;
      tx_valid_q <= 1'b0;
      tx_eof_q <= 1'b0;
      tx_is_lb_q <= 1'b0;
      overrun_q <= 1'b0;
      gbe_cnt_q <= '0;
      lb_cnt_q <= '0;
    end else begin
      tx_valid_q <= 1'b0;
      tx_eof_q <= 1'b0;
      if (bus.ce) begin
        gbe_dly_q <= RD_LATENCY'({gbe_dly_q, bus.gbe_re});
        lb_dly_q <= RD_LATENCY'({lb_dly_q, bus.lb_re});
        if (state_q == SEND) begin
          tx_data_q <= pkt_q[idx_q];
          tx_valid_q <= 1'b1;
          tx_eof_q <= last;
          idx_q <= idx_q + 1'b1;
          if (last) begin
            state_q <= IDLE;
            if (tx_is_lb_q) lb_cnt_q <= lb_cnt_q + 1'b1;
            else gbe_cnt_q <= gbe_cnt_q + 1'b1;
          end
        end
        if (accept) begin
          pkt_q <= gbe_ld ? bus.gbe_dout : bus.lb_dout;
          tx_dest_ip_q <= gbe_ld ? bus.gbe_dest_ip : bus.lb_dest_ip;
          tx_is_lb_q <= !gbe_ld;
          idx_q <= '0;
          state_q <= SEND;
        end
        if ((gbe_ld || lb_ld) && (!accept || (gbe_ld && lb_ld))) overrun_q <= 1'b1;
      end
    end
  end
  assign bus.tx_data = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_eof = tx_eof_q;
  assign bus.tx_dest_ip = tx_dest_ip_q;
  assign bus.tx_is_lb = tx_is_lb_q;
  assign bus.gbe_pkt_cnt = gbe_cnt_q;
  assign bus.lb_pkt_cnt = lb_cnt_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_gbe_tx_serializer.sv
// tb_gbe_tx_serializer: scenario tasks plus a schedule-based scoreboard of expected tx words.
module tb_gbe_tx_serializer;
  localparam int N = 7;
  localparam int W = 64;
  localparam int PB = N * W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gbe_tx_if #(.WORDS_PER_PACKET(N), .WORD_BITS(W), .PKT_CTR_BITS(32)) bus ();
  gbe_tx_serializer #(
    .WORDS_PER_PACKET(N), .WORDS_PER_PACKET_BITS(3), .WORD_BITS(W), .RD_LATENCY(1), .PKT_CTR_BITS(32)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  // Reference model: an accepted load at ce-cycle L schedules word k for ce-cycle L+1+k
  typedef struct {logic [W-1:0] d; logic eof; int due;} word_t;
  word_t exp_q[$];
  word_t w;
  int n = 0;
  int busy_end = -1;
  bit armed = 0;
  bit pg = 0, pl = 0;
  logic [31:0] m_gcnt, m_lcnt, m_ip;
  logic m_lb, m_ovr;
  logic s_rst, s_ce, s_g, s_l;
  logic [PB-1:0] s_gd, s_ld, src;
  logic [31:0] s_gip, s_lip;
  logic e_valid, e_eof;
  logic [W-1:0] e_data;
  logic [W-1:0] obs_d[$];
  int obs_c[$];
  logic obs_lb[$], obs_eof[$];
  always begin
    @(posedge clk);
    s_rst = rst; s_ce = bus.ce; s_g = bus.gbe_re; s_l = bus.lb_re;
    s_gd = bus.gbe_dout; s_ld = bus.lb_dout; s_gip = bus.gbe_dest_ip; s_lip = bus.lb_dest_ip;
    cyc++;
    #1;
    e_valid = 0; e_eof = 0; e_data = '0;
    if (s_rst) begin
      exp_q.delete(); n = 0; busy_end = -1; pg = 0; pl = 0; armed = 1;
      m_gcnt = 0; m_lcnt = 0; m_ip = 0; m_lb = 0; m_ovr = 0;
    end else if (s_ce) begin
      if (exp_q.size() > 0 && exp_q[0].due == n) begin
        w = exp_q.pop_front();
        e_valid = 1; e_eof = w.eof; e_data = w.d;
        if (w.eof) begin
          if (m_lb) m_lcnt++;
          else m_gcnt++;
        end
      end
      if (pg || pl) begin
        if (pg && pl) m_ovr = 1;
        if (n < busy_end) m_ovr = 1;
        else begin
          src = pg ? s_gd : s_ld;
          m_ip = pg ? s_gip : s_lip;
          m_lb = !pg;
          for (int k = 0; k < N; k++) exp_q.push_back('{d: src[k*W +: W], eof: (k == N - 1), due: n + 1 + k});
          busy_end = n + N;
        end
      end
      pg = s_g; pl = s_l; n++;
    end
    if (armed) begin
      if (bus.tx_valid === 1'b1) begin
        obs_d.push_back(bus.tx_data); obs_c.push_back(cyc); obs_lb.push_back(bus.tx_is_lb); obs_eof.push_back(bus.tx_eof);
      end
      checks += 7;
      if (bus.tx_valid !== e_valid) begin errors++; $display("FAIL tx_valid cyc %0d: got %b expected %b", cyc, bus.tx_valid, e_valid); end
      if (bus.tx_eof !== e_eof) begin errors++; $display("FAIL tx_eof cyc %0d: got %b expected %b", cyc, bus.tx_eof, e_eof); end
      if (bus.tx_dest_ip !== m_ip) begin errors++; $display("FAIL tx_dest_ip cyc %0d: got %h expected %h", cyc, bus.tx_dest_ip, m_ip); end
      if (bus.tx_is_lb !== m_lb) begin errors++; $display("FAIL tx_is_lb cyc %0d: got %b expected %b", cyc, bus.tx_is_lb, m_lb); end
      if (bus.gbe_pkt_cnt !== m_gcnt) begin errors++; $display("FAIL gbe_pkt_cnt cyc %0d: got %0d expected %0d", cyc, bus.gbe_pkt_cnt, m_gcnt); end
      if (bus.lb_pkt_cnt !== m_lcnt) begin errors++; $display("FAIL lb_pkt_cnt cyc %0d: got %0d expected %0d", cyc, bus.lb_pkt_cnt, m_lcnt); end
      if (bus.overrun !== m_ovr) begin errors++; $display("FAIL overrun cyc %0d: got %b expected %b", cyc, bus.overrun, m_ovr); end
      if (e_valid || s_rst) begin
        checks++;
        if (bus.tx_data !== e_data) begin errors++; $display("FAIL tx_data cyc %0d: got %h expected %h", cyc, bus.tx_data, e_data); end
      end
    end
  end
  task automatic tick(int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1; bus.gbe_re = 0; bus.lb_re = 0;
    tick(2);
    rst = 0;
  endtask
  task automatic clear_obs();
    obs_d.delete(); obs_c.delete(); obs_lb.delete(); obs_eof.delete();
  endtask
  task automatic rand_pkt(output logic [PB-1:0] p);
    for (int i = 0; i < PB / 32; i++) p[i*32 +: 32] = $urandom;
  endtask
  task automatic test_reset();
    bus.ce = 0; bus.gbe_re = 0; bus.lb_re = 0; bus.gbe_dout = '0; bus.lb_dout = '0;
    bus.gbe_dest_ip = 0; bus.lb_dest_ip = 0;
    do_reset();
    checks += 4;
    if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.tx_valid); end
    if (bus.gbe_pkt_cnt !== 0 || bus.lb_pkt_cnt !== 0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", bus.gbe_pkt_cnt, bus.lb_pkt_cnt); end
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
    if (bus.tx_data !== '0 || bus.tx_dest_ip !== 0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0/0", bus.tx_data, bus.tx_dest_ip); end
  endtask
  task automatic test_single_gbe();
    int sc;
    do_reset();
    bus.ce = 1;
    for (int k = 0; k < N; k++) bus.gbe_dout[k*W +: W] = 64'h1000 + 64'(k);
    bus.gbe_dest_ip = 32'h0A000001;
    clear_obs();
    tick(3);
    bus.gbe_re = 1; sc = cyc + 1;
    tick(1);
    bus.gbe_re = 0;
    tick(12);
    checks += 4;
    if (obs_d.size() != N) begin errors++; $display("FAIL single_count: got %0d expected %0d", obs_d.size(), N); end
    else begin
      for (int k = 0; k < N; k++) begin
        checks += 2;
        if (obs_d[k] !== 64'h1000 + 64'(k)) begin errors++; $display("FAIL single_word%0d: got %h expected %h", k, obs_d[k], 64'h1000 + 64'(k)); end
        if (obs_eof[k] !== (k == N - 1)) begin errors++; $display("FAIL single_eof%0d: got %b", k, obs_eof[k]); end
      end
      checks++;
      if (obs_c[0] - sc != 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", obs_c[0] - sc); end
    end
    if (bus.gbe_pkt_cnt !== 1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", bus.gbe_pkt_cnt); end
    if (bus.tx_dest_ip !== 32'h0A000001) begin errors++; $display("FAIL single_ip: got %h expected 0a000001", bus.tx_dest_ip); end
    if (bus.tx_is_lb !== 1'b0) begin errors++; $display("FAIL single_is_lb: got %b expected 0", bus.tx_is_lb); end
  endtask
  task automatic test_back_to_back();
    logic [PB-1:0] p;
    do_reset();
    bus.ce = 1; bus.gbe_dest_ip = $urandom; bus.lb_dest_ip = $urandom;
    clear_obs();
    for (int i = 0; i < 10; i++) begin
      rand_pkt(p);
      if (i % 2 == 0) begin bus.gbe_dout = p; bus.gbe_re = 1; end
      else begin bus.lb_dout = p; bus.lb_re = 1; end
      tick(1);
      bus.gbe_re = 0; bus.lb_re = 0;
      tick(6);
    end
    tick(12);
    checks += 3;
    if (obs_d.size() != 10 * N) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", obs_d.size(), 10 * N); end
    else begin
      checks++;
      if (obs_c[10*N-1] - obs_c[0] != 10 * N - 1) begin errors++; $display("FAIL b2b_gap: got span %0d expected %0d", obs_c[10*N-1] - obs_c[0], 10 * N - 1); end
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (obs_lb[i*N] !== logic'(i % 2)) begin errors++; $display("FAIL b2b_is_lb pkt%0d: got %b expected %0d", i, obs_lb[i*N], i % 2); end
      end
    end
    if (bus.gbe_pkt_cnt !== 5 || bus.lb_pkt_cnt !== 5) begin errors++; $display("FAIL b2b_cnt: got %0d/%0d expected 5/5", bus.gbe_pkt_cnt, bus.lb_pkt_cnt); end
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", bus.overrun); end
  endtask
  task automatic test_ce_toggle();
    logic [PB-1:0] p;
    do_reset();
    clear_obs();
    rand_pkt(p);
    bus.ce = 1; bus.lb_dout = p; bus.lb_dest_ip = $urandom; bus.lb_re = 1;
    tick(1);
    bus.lb_re = 0;
    for (int i = 0; i < 40; i++) begin bus.ce = ~bus.ce; tick(1); end
    bus.ce = 1;
    tick(3);
    checks++;
    if (obs_d.size() != N) begin errors++; $display("FAIL ce_count: got %0d expected %0d", obs_d.size(), N); end
    else for (int k = 0; k < N; k++) begin
      checks++;
      if (obs_d[k] !== p[k*W +: W]) begin errors++; $display("FAIL ce_word%0d: got %h expected %h", k, obs_d[k], p[k*W +: W]); end
      if (k > 0) begin
        checks++;
        if (obs_c[k] - obs_c[k-1] != 2) begin errors++; $display("FAIL ce_spacing%0d: got %0d expected 2", k, obs_c[k] - obs_c[k-1]); end
      end
    end
  endtask
  task automatic test_overrun();
    logic [PB-1:0] a, b;
    do_reset();
    clear_obs();
    rand_pkt(a); rand_pkt(b);
    bus.ce = 1; bus.lb_dout = a; bus.lb_re = 1;
    tick(1);
    bus.lb_re = 0;
    tick(2);
    bus.lb_dout = b; bus.lb_re = 1;
    tick(1);
    bus.lb_re = 0;
    tick(12);
    checks += 2;
    if (obs_d.size() != N) begin errors++; $display("FAIL ovr_count: got %0d expected %0d", obs_d.size(), N); end
    else for (int k = 0; k < N; k++) begin
      checks++;
      if (obs_d[k] !== a[k*W +: W]) begin errors++; $display("FAIL ovr_word%0d: got %h expected %h", k, obs_d[k], a[k*W +: W]); end
    end
    if (bus.overrun !== 1'b1 || bus.lb_pkt_cnt !== 1) begin errors++; $display("FAIL ovr_flag: got %b cnt %0d expected 1 cnt 1", bus.overrun, bus.lb_pkt_cnt); end
    tick(20);
    checks++;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", bus.overrun); end
    do_reset();
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", bus.overrun); end
  endtask
  task automatic test_simultaneous();
    logic [PB-1:0] g, l;
    do_reset();
    clear_obs();
    rand_pkt(g); rand_pkt(l);
    bus.ce = 1; bus.gbe_dout = g; bus.lb_dout = l; bus.gbe_re = 1; bus.lb_re = 1;
    tick(1);
    bus.gbe_re = 0; bus.lb_re = 0;
    tick(12);
    checks += 3;
    if (obs_d.size() != N) begin errors++; $display("FAIL sim_count: got %0d expected %0d", obs_d.size(), N); end
    else for (int k = 0; k < N; k++) begin
      checks++;
      if (obs_d[k] !== g[k*W +: W]) begin errors++; $display("FAIL sim_word%0d: got %h expected %h", k, obs_d[k], g[k*W +: W]); end
    end
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL sim_overrun: got %b expected 1", bus.overrun); end
    if (bus.gbe_pkt_cnt !== 1 || bus.lb_pkt_cnt !== 0) begin errors++; $display("FAIL sim_cnt: got %0d/%0d expected 1/0", bus.gbe_pkt_cnt, bus.lb_pkt_cnt); end
  endtask
  task automatic test_reset_mid_packet();
    logic [PB-1:0] p;
    do_reset();
    clear_obs();
    rand_pkt(p);
    bus.ce = 1; bus.gbe_dout = p; bus.gbe_re = 1;
    tick(1);
    bus.gbe_re = 0;
    for (int i = 0; i < 20 && obs_d.size() < 4; i++) tick(1);
    checks++;
    if (obs_d.size() != 4) begin errors++; $display("FAIL mid_reach_word3: got %0d words expected 4", obs_d.size()); end
    rst = 1;
    tick(1);
    checks += 2;
    if (bus.tx_valid !== 1'b0 || bus.tx_eof !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b/%b expected 0/0", bus.tx_valid, bus.tx_eof); end
    if (bus.gbe_pkt_cnt !== 0) begin errors++; $display("FAIL mid_cnt: got %0d expected 0", bus.gbe_pkt_cnt); end
    rst = 0;
    clear_obs();
    tick(10);
    checks++;
    if (obs_d.size() != 0) begin errors++; $display("FAIL mid_residue: got %0d words expected 0", obs_d.size()); end
    rand_pkt(p);
    bus.gbe_dout = p; bus.gbe_re = 1;
    tick(1);
    bus.gbe_re = 0;
    tick(12);
    checks += 2;
    if (obs_d.size() != N) begin errors++; $display("FAIL mid_count: got %0d expected %0d", obs_d.size(), N); end
    else for (int k = 0; k < N; k++) begin
      checks++;
      if (obs_d[k] !== p[k*W +: W]) begin errors++; $display("FAIL mid_word%0d: got %h expected %h", k, obs_d[k], p[k*W +: W]); end
    end
    if (bus.gbe_pkt_cnt !== 1) begin errors++; $display("FAIL mid_cnt_after: got %0d expected 1", bus.gbe_pkt_cnt); end
  endtask
  task automatic test_random();
    logic [PB-1:0] p;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.ce = ($urandom_range(0, 3) != 0);
      bus.gbe_re = ($urandom_range(0, 9) == 0);
      bus.lb_re = ($urandom_range(0, 9) == 0);
      rand_pkt(p); bus.gbe_dout = p;
      rand_pkt(p); bus.lb_dout = p;
      bus.gbe_dest_ip = $urandom; bus.lb_dest_ip = $urandom;
      tick(1);
    end
    bus.ce = 1; bus.gbe_re = 0; bus.lb_re = 0;
    tick(15);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d words pending expected 0", exp_q.size()); end
  endtask
  initial begin
    test_reset();
    test_single_gbe();
    test_back_to_back();
    test_ce_toggle();
    test_overrun();
    test_simultaneous();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gbe_tx_serializer.md
Name: gbe_tx_serializer

Overview:
- Sits directly downstream of the gbe/loopback FIFO read arbiter.
- Consumes the one-cycle read strobes (gbe_re, lb_re) and the wide FIFO output words; each FIFO entry holds one whole packet.
- Serializes each entry into WORDS_PER_PACKET consecutive words on the 10GbE tx interface, with a per-packet destination IP, an end-of-frame flag and per-source packet counters.

Parameters:
WORDS_PER_PACKET, 7, tx words per packet (one FIFO entry)
WORDS_PER_PACKET_BITS, 3, width of word index; must satisfy 2^WORDS_PER_PACKET_BITS >= WORDS_PER_PACKET
WORD_BITS, 64, tx word width
RD_LATENCY, 1, FIFO read latency in ce-enabled cycles (>=1)
PKT_CTR_BITS, 32, width of packet counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ce  in  1  clock enable
gbe_re  in  1  gbe FIFO read strobe (from arbiter)
lb_re  in  1  loopback FIFO read strobe (from arbiter)
gbe_dout  in  WORDS_PER_PACKET*WORD_BITS  gbe FIFO data
lb_dout  in  WORDS_PER_PACKET*WORD_BITS  loopback FIFO data
gbe_dest_ip  in  32  destination IP for gbe packets
lb_dest_ip  in  32  destination IP for loopback packets
tx_data  out  WORD_BITS  tx word
tx_valid  out  1  tx word valid
tx_eof  out  1  last word of packet
tx_dest_ip  out  32  destination IP, constant across a packet
tx_is_lb  out  1  current packet came from loopback FIFO
gbe_pkt_cnt  out  PKT_CTR_BITS  gbe packets sent
lb_pkt_cnt  out  PKT_CTR_BITS  loopback packets sent
overrun  out  1  sticky error flag

Behaviour:
Reset:
- rst overrides ce.
- All outputs 0, state IDLE, strobe delay line cleared, counters 0, overrun 0.

Clock enable:
- Strobe delay line, state, index and counters advance only when ce=1.
- Any clk with ce=0: tx_valid and tx_eof register 0; all other state held. This prevents duplicate words.

Load:
- gbe_re/lb_re pass through a RD_LATENCY-stage ce-gated delay line.
- A load occurs on a ce cycle where a delayed strobe is 1. On a load:
  - latch the matching *_dout and *_dest_ip;
  - set tx_is_lb;
  - word index = 0;
  - enter SEND.
- Data is sampled in the same cycle the delayed strobe is seen.

Latency:
- Strobe on ce cycle t gives the load at t+RD_LATENCY.
- First tx_valid is registered at t+RD_LATENCY+1, with continuous ce.

States:
- IDLE: tx_valid=0. Load goes to SEND.
- SEND, each ce cycle:
  - tx_data = latched bits [idx*WORD_BITS +: WORD_BITS]; word 0 is the LSBs.
  - tx_valid=1; tx_eof=1 iff idx==WORDS_PER_PACKET-1.
  - idx increments.
  - After the eof word: go to IDLE, or stay in SEND if a load coincides with the eof cycle (back-to-back, no gap).

Output stability:
- tx_dest_ip and tx_is_lb change only on a load; they are stable for all words of a packet.

Counters:
- gbe_pkt_cnt/lb_pkt_cnt increment (per tx_is_lb) in the cycle tx_eof is asserted.
- They wrap modulo 2^PKT_CTR_BITS.

Errors (overrun, sticky until rst):
- Load while in SEND on a non-eof word: load ignored, current packet completes unaltered, overrun set.
- Both delayed strobes in the same load cycle: gbe wins, lb data dropped, overrun set.

Arbiter interaction:
- With the arbiter issuing strobes no more often than every WORDS_PER_PACKET ce cycles, overrun never sets.

Test Plan:
- Single gbe packet: rst 2 cycles, ce=1, gbe_dout word k = 0x1000+k, gbe_dest_ip=0x0A000001, one gbe_re pulse at cycle 10 -> tx_valid cycles 12..18 with tx_data 0x1000..0x1006, tx_eof only at 18, tx_dest_ip 0x0A000001, tx_is_lb=0, gbe_pkt_cnt=1.
- Alternating gbe/lb strobes every 7 cycles (arbiter pattern), 10 packets -> continuous tx_valid with no gaps, tx_is_lb toggles at each packet boundary, gbe_pkt_cnt=5, lb_pkt_cnt=5, overrun=0.
- ce toggling 1,0,1,0 during a packet -> exactly 7 tx_valid pulses, each one clk wide, no duplicated or skipped words.
- Overrun: lb_re pulses 3 cycles apart -> first packet intact (7 words, lb data), second dropped, overrun=1 and held until rst.
- Simultaneous gbe_re and lb_re -> gbe packet sent, lb dropped, overrun=1.
- Reset mid-packet (rst at word 3) -> tx_valid 0 next cycle, counters 0, no eof emitted; next strobe produces a full clean packet.
